// File: rtl/mpsoc_bb_arb_pkg.sv
// Shared types and width helpers for the Blackbone external-port arbiter.
// Optional feature macro: MPSOC_BB_ARB_RR_EN (round-robin when defined).
package mpsoc_bb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } bb_arb_state_t;

  // Latency counter must be able to hold RD_LATENCY itself.
  function automatic int bb_arb_cnt_w(input int rd_latency);
    return $clog2(rd_latency + 1);
  endfunction

  // Requester index width; never narrower than one bit.
  function automatic int bb_arb_idx_w(input int nodes);
    return (nodes < 2) ? 1 : $clog2(nodes);
  endfunction

  // Widths for the default configuration (NODES=8, RD_LATENCY=1).
  localparam int BB_ARB_CNT_W_DFLT = bb_arb_cnt_w(1);
  localparam int BB_ARB_IDX_W_DFLT = bb_arb_idx_w(8);

endpackage

// File: rtl/mpsoc_rr_arbiter.sv
// Combinational winner select: request vector (+ last-grant pointer) to
// one-hot grant and index. Round-robin when MPSOC_BB_ARB_RR_EN is defined,
// otherwise a lowest-index-wins priority encoder.
module mpsoc_rr_arbiter
  import mpsoc_bb_arb_pkg::*;
#(
  parameter int NODES = 8,
  parameter int IW    = bb_arb_idx_w(NODES)
) (
  input  logic [NODES-1:0] req,
`ifdef MPSOC_BB_ARB_RR_EN
  input  logic [IW-1:0]    last_grant,
`endif
  output logic [NODES-1:0] grant,
  output logic [IW-1:0]    idx,
  output logic             valid
);

  logic          found;
`ifdef MPSOC_BB_ARB_RR_EN
  logic [IW-1:0] cand;
`endif

  assign valid = |req;

  // Scan requesters and pick the first one in priority order.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
`ifdef MPSOC_BB_ARB_RR_EN
    cand  = '0;
    // Search starts just after the last winner and wraps around.
    for (int k = 1; k <= NODES; k++) begin
      cand = IW'((int'(last_grant) + k) % NODES);
      if (!found && req[cand]) begin
        found       = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
`else
    for (int k = 0; k < NODES; k++) begin
      if (!found && req[k]) begin
        found    = 1'b1;
        idx      = IW'(k);
        grant[k] = 1'b1;
      end
    end
`endif
  end

endmodule

// File: rtl/mpsoc_bb_ext_arbiter.sv
// Shares one external Blackbone memory port among NODES tile requesters.
// One access at a time: grant, drive the shared port for one cycle, wait
// out the read latency, capture read data, pulse a one-cycle ack.
// Optional feature macro: MPSOC_BB_ARB_RR_EN (round-robin; fixed priority
// with lowest index winning when undefined).
module mpsoc_bb_ext_arbiter
  import mpsoc_bb_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int NODES      = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NODES-1:0][AW-1:0]  req_addr,
  input  logic [NODES-1:0][DW-1:0]  req_din,
  input  logic [NODES-1:0]          req_en,
  input  logic [NODES-1:0]          req_we,
  output logic [NODES-1:0][DW-1:0]  req_dout,
  output logic [NODES-1:0]          req_ack,
  output logic [AW-1:0]             mem_addr,
  output logic [DW-1:0]             mem_din,
  output logic                      mem_en,
  output logic                      mem_we,
  input  logic [DW-1:0]             mem_dout
);

  localparam int IW = bb_arb_idx_w(NODES);
  localparam int CW = bb_arb_cnt_w(RD_LATENCY);

  bb_arb_state_t    state;
  logic [IW-1:0]    idx_reg;
  logic [NODES-1:0] sel_reg;
  logic             we_reg;
  logic [CW-1:0]    cnt;

  logic [NODES-1:0] win_hot;
  logic [IW-1:0]    win_idx;
  logic             win_valid;

`ifdef MPSOC_BB_ARB_RR_EN
  logic [IW-1:0]    last_grant;
`endif

  mpsoc_rr_arbiter #(
    .NODES (NODES),
    .IW    (IW)
  ) u_arb (
    .req        (req_en),
`ifdef MPSOC_BB_ARB_RR_EN
    .last_grant (last_grant),
`endif
    .grant      (win_hot),
    .idx        (win_idx),
    .valid      (win_valid)
  );

  // Access sequencer: all outputs are registers; mem_en/mem_we/req_ack
  // default low so they are single-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx_reg    <= '0;
      sel_reg    <= '0;
      we_reg     <= 1'b0;
      cnt        <= '0;
      mem_addr   <= '0;
      mem_din    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      req_ack    <= '0;
      req_dout   <= '0;
`ifdef MPSOC_BB_ARB_RR_EN
      last_grant <= IW'(NODES - 1);
`endif
    end else begin
      mem_en  <= 1'b0;
      mem_we  <= 1'b0;
      req_ack <= '0;
      case (state)
        IDLE: begin
          // Latch the winner's request; later changes by the requester are ignored.
          if (win_valid) begin
            idx_reg  <= win_idx;
            sel_reg  <= win_hot;
            we_reg   <= req_we[win_idx];
            mem_addr <= req_addr[win_idx];
            mem_din  <= req_din[win_idx];
            mem_en   <= 1'b1;
            mem_we   <= req_we[win_idx];
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (we_reg) begin
            req_ack <= sel_reg;
            state   <= RESP;
          end else begin
            cnt   <= CW'(RD_LATENCY);
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - CW'(1);
          // Last latency cycle: memory data is valid now.
          if (cnt == CW'(1)) begin
            req_dout[idx_reg] <= mem_dout;
            req_ack           <= sel_reg;
            state             <= RESP;
          end
        end
        RESP: begin
`ifdef MPSOC_BB_ARB_RR_EN
          last_grant <= idx_reg;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpsoc_bb_ext_arbiter.sv
// Directed bench for mpsoc_bb_ext_arbiter (NODES=8, RD_LATENCY=2).
// Expectations adapt to MPSOC_BB_ARB_RR_EN for the arbitration-order test.
module tb_mpsoc_bb_ext_arbiter;

  localparam int NODES = 8;
  localparam int RDL   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NODES-1:0][31:0] req_addr;
  logic [NODES-1:0][31:0] req_din;
  logic [NODES-1:0]      req_en;
  logic [NODES-1:0]      req_we;
  logic [NODES-1:0][31:0] req_dout;
  logic [NODES-1:0]      req_ack;
  logic [31:0]           mem_addr;
  logic [31:0]           mem_din;
  logic                  mem_en;
  logic                  mem_we;
  logic [31:0]           mem_dout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mpsoc_bb_ext_arbiter #(
    .AW(32), .DW(32), .NODES(NODES), .RD_LATENCY(RDL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_addr (req_addr),
    .req_din  (req_din),
    .req_en   (req_en),
    .req_we   (req_we),
    .req_dout (req_dout),
    .req_ack  (req_ack),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_dout (mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model contents: 0x40 holds 0x12345678, otherwise addr/~addr halves.
  function automatic logic [31:0] rd_data(input logic [31:0] a);
    return (a == 32'h40) ? 32'h12345678 : {a[15:0], ~a[15:0]};
  endfunction

  // Read pipeline: data valid RDL cycles after the mem_en cycle, garbage otherwise.
  logic        rd_s1 = 1'b0, rd_s2 = 1'b0;
  logic [31:0] a1 = '0, a2 = '0;
  always @(posedge clk) begin
    rd_s1 <= mem_en && !mem_we;
    a1    <= mem_addr;
    rd_s2 <= rd_s1;
    a2    <= a1;
  end
  assign mem_dout = rd_s2 ? rd_data(a2) : 32'hBAD0BAD0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // At most one ack bit in any cycle.
  always @(negedge clk) begin
    if (!rst) chk("ack_onehot", 32'($countones(req_ack) <= 1), 32'd1);
  end

  function automatic int ack_idx(input logic [NODES-1:0] a);
    for (int i = 0; i < NODES; i++) if (a[i]) return i;
    return -1;
  endfunction

  // One complete transaction from a single requester, checking port and ack timing.
  task automatic run_txn(input int idx, input logic we, input logic [31:0] addr,
                         input logic [31:0] din, input int exp_lat,
                         input logic [31:0] exp_dout);
    int lat;
    @(negedge clk);
    req_en[idx] = 1'b1; req_we[idx] = we; req_addr[idx] = addr; req_din[idx] = din;
    @(negedge clk);
    chk("mem_en", 32'(mem_en), 32'd1);
    chk("mem_we", 32'(mem_we), 32'(we));
    chk("mem_addr", mem_addr, addr);
    chk("mem_din", mem_din, din);
    // Changes after grant must be ignored.
    req_addr[idx] = ~addr; req_din[idx] = ~din; req_we[idx] = ~we;
    lat = 1;
    while (req_ack == '0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("ack_vec", 32'(req_ack), 32'(1) << idx);
    chk("ack_lat", 32'(lat), 32'(exp_lat));
    chk("ack_mem_en_low", 32'(mem_en), 32'd0);
    chk("req_dout", req_dout[idx], exp_dout);
    $display("txn node %0d we %0d addr %h din %h lat %0d dout %h", idx, we, addr, din, lat, req_dout[idx]);
    req_en[idx] = 1'b0;
  endtask

  typedef struct {
    int          idx;
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    int          lat;
    logic [31:0] dout;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat;
    int n_en, n_ack;
    int en_cyc[$];
    int order[$];
    int exp_order[6];
    vecs[0] = '{3, 1'b1, 32'h00000100, 32'hDEADBEEF, 2,       32'h00000000};
    vecs[1] = '{5, 1'b0, 32'h00000040, 32'h00000000, 2 + RDL, 32'h12345678};
    vecs[2] = '{5, 1'b1, 32'h00000044, 32'hCAFEF00D, 2,       32'h12345678};
    vecs[3] = '{0, 1'b0, 32'h00001234, 32'h00000000, 2 + RDL, 32'h1234EDCB};
    vecs[4] = '{7, 1'b0, 32'h00008000, 32'h00000000, 2 + RDL, 32'h80007FFF};
    vecs[5] = '{6, 1'b1, 32'hFFFFFFFC, 32'h00000000, 2,       32'h00000000};

    req_addr = '0; req_din = '0; req_en = '0; req_we = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_din", mem_din, 32'd0);
    chk("rst_req_ack", 32'(req_ack), 32'd0);
    chk("rst_req_dout", 32'(|req_dout), 32'd0);
    rst = 1'b0;

    for (int v = 0; v < 6; v++)
      run_txn(vecs[v].idx, vecs[v].we, vecs[v].addr, vecs[v].din, vecs[v].lat, vecs[v].dout);
    chk("untouched_dout4", req_dout[4], 32'd0);
    chk("untouched_dout3", req_dout[3], 32'd0);

    // Reset during WAIT of a read from node 2; nodes 6 and 7 pending.
    @(negedge clk);
    req_en[2] = 1'b1; req_we[2] = 1'b0; req_addr[2] = 32'h80;
    @(negedge clk);
    chk("rr_read_mem_en", 32'(mem_en), 32'd1);
    @(negedge clk);
    req_en[2] = 1'b0;
    req_en[6] = 1'b1; req_we[6] = 1'b1; req_addr[6] = 32'h600; req_din[6] = 32'h6;
    req_en[7] = 1'b1; req_we[7] = 1'b1; req_addr[7] = 32'h700; req_din[7] = 32'h7;
    rst = 1'b1;
    #1;
    chk("midrst_mem_en", 32'(mem_en), 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    chk("midrst_ack", 32'(req_ack), 32'd0);
    chk("midrst_dout", 32'(|req_dout), 32'd0);
    @(negedge clk);
    chk("midrst_ack2", 32'(req_ack), 32'd0);
    rst = 1'b0;
    lat = 0;
    while (req_ack == '0 && lat < 20) begin @(negedge clk); lat++; end
    chk("post_rst_first", 32'(req_ack), 32'h40);
    $display("txn post-reset grant ack %b", req_ack);
    req_en[6] = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (req_ack == '0 && lat < 20);
    chk("post_rst_second", 32'(req_ack), 32'h80);
    $display("txn post-reset grant ack %b", req_ack);
    req_en[7] = 1'b0;

    // Withdrawal after grant: read on node 1, req_en dropped in r+1.
    @(negedge clk);
    req_en[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h40;
    @(negedge clk);
    chk("wd_mem_en", 32'(mem_en), 32'd1);
    req_en[1] = 1'b0;
    lat = 1;
    while (req_ack == '0 && lat < 20) begin @(negedge clk); lat++; end
    chk("wd_ack", 32'(req_ack), 32'h02);
    chk("wd_lat", 32'(lat), 32'(2 + RDL));
    chk("wd_dout", req_dout[1], 32'h12345678);
    $display("txn withdrawn read node 1 lat %0d dout %h", lat, req_dout[1]);

    // Back-to-back writes from node 4 with req_en held across acks.
    @(negedge clk);
    req_en[4] = 1'b1; req_we[4] = 1'b1; req_addr[4] = 32'h300; req_din[4] = 32'h1;
    n_ack = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_en) en_cyc.push_back(cyc);
      if (req_ack[4]) n_ack++;
    end
    req_en[4] = 1'b0;
    n_en = en_cyc.size();
    chk("b2b_mem_en_count", 32'(n_en), 32'd3);
    chk("b2b_ack_count", 32'(n_ack), 32'd3);
    if (n_en >= 2) chk("b2b_spacing", 32'(en_cyc[1] - en_cyc[0]), 32'd3);
    $display("txn back-to-back node 4 accesses %0d acks %0d", n_en, n_ack);

    // Arbitration order with nodes 0, 2, 7 held continuously from reset.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_en[0] = 1'b1; req_we[0] = 1'b1;
    req_en[2] = 1'b1; req_we[2] = 1'b1;
    req_en[7] = 1'b1; req_we[7] = 1'b1;
`ifdef MPSOC_BB_ARB_RR_EN
    exp_order = '{0, 2, 7, 0, 2, 7};
`else
    exp_order = '{0, 0, 0, 0, 0, 0};
`endif
    lat = 0;
    while (order.size() < 6 && lat < 60) begin
      @(negedge clk);
      lat++;
      if (req_ack != '0) begin
        order.push_back(ack_idx(req_ack));
        $display("txn arbitration grant %0d -> node %0d", order.size() - 1, ack_idx(req_ack));
      end
    end
    req_en = '0;
    chk("arb_grant_count", 32'(order.size()), 32'd6);
    for (int k = 0; k < 6; k++)
      if (k < order.size()) chk("arb_order", 32'(order[k]), 32'(exp_order[k]));

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mpsoc_bb_ext_arbiter.md
# mpsoc_bb_ext_arbiter

Shares one external Blackbone memory port among `NODES` tile-side Blackbone requesters (`bb_ext_*` per tile) in the MPSoC-MSP430 mesh. It grants one request at a time, by round-robin or fixed priority. It sequences the access on the shared port, handling the fixed read latency. It returns read data and a one-cycle acknowledge to the winning requester. It sits between the per-tile `bb_ext_*` outputs of the 3D mesh top level and a single external memory.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `NODES`, 8, number of requesters (≥2)
- `RD_LATENCY`, 1, cycles from `mem_en` cycle to valid `mem_dout` (≥1)

Ports (`clk` is the single clock; `rst` is asynchronous, active-high):
- `clk`  in  1  clock
- `rst`  in  1  asynchronous reset, active-high
- `req_addr`  in  [NODES-1:0][AW-1:0]  per-requester address
- `req_din`  in  [NODES-1:0][DW-1:0]  per-requester write data
- `req_en`  in  [NODES-1:0]  request valid, held until ack
- `req_we`  in  [NODES-1:0]  1 = write, 0 = read
- `req_dout`  out  [NODES-1:0][DW-1:0]  per-requester read data register
- `req_ack`  out  [NODES-1:0]  one-cycle completion pulse
- `mem_addr`  out  AW  shared port address
- `mem_din`  out  DW  shared port write data
- `mem_en`  out  1  shared port enable
- `mem_we`  out  1  shared port write enable
- `mem_dout`  in  DW  shared port read data

## Operation
- FSM states: IDLE, ACCESS, WAIT, RESP.
- **IDLE:** if any `req_en`, the arbiter picks a winner and latches its addr, din, we and index, then goes to ACCESS. Otherwise it stays in IDLE.
- **ACCESS (1 cycle):** `mem_en`=1 and `mem_we`=latched we, with the latched addr/din.
  - Write: go to RESP.
  - Read: go to WAIT with the counter set to `RD_LATENCY`.
- **WAIT:** the counter decrements each cycle. At the end of the cycle where it reaches 1, `mem_dout` is captured into `req_dout[winner]` and the FSM goes to RESP.
- **RESP (1 cycle):** `req_ack[winner]`=1. The priority pointer is updated to the winner, then the FSM returns to IDLE.
- Requester contract:
  - The request is latched at grant. Changes to addr/din/we after grant are ignored.
  - Dropping `req_en` after grant does not abort the access. The ack is still pulsed.
  - `req_en` still high in the cycle after the ack is treated as a new request.
- `req_dout[i]` holds the last read data for requester i. Writes never modify it.
- Outside ACCESS, `mem_en`=`mem_we`=0, and `mem_addr`/`mem_din` hold their last latched values.
- Round-robin arbitration: the search starts at `last_grant+1` mod `NODES` and wraps.
- At most one `req_ack` bit is high in any cycle.

## Timing
- Reset values:
  - State = IDLE.
  - `mem_en`, `mem_we`, `mem_addr`, `mem_din`, `req_ack`, `req_dout` = 0.
  - `last_grant` = `NODES`-1, so requester 0 has first priority.
- Request sampled in IDLE in cycle r:
  - `mem_en` is high in cycle r+1.
  - Write ack arrives in r+2.
  - Read ack arrives in r+2+`RD_LATENCY`, with `req_dout` valid in the same cycle.
- Throughput: a write takes 3 cycles and a read takes 3+`RD_LATENCY` cycles, including the return to IDLE.
- All outputs are registered.
- Simultaneous requests in the same IDLE cycle: exactly one is granted; the others wait, with `req_en` held.
- Reset mid-operation: everything returns to reset values immediately (asynchronous). No ack is issued, and `mem_en` drops in the same cycle.

## Configuration
- `MPSOC_BB_ARB_RR_EN`:
  - Defined: round-robin arbitration with the `last_grant` pointer.
  - Undefined: fixed priority, where the lowest index wins; the `last_grant` register is not built.

## Structure
- Package `mpsoc_bb_arb_pkg`: state enum typedef (`bb_arb_state_t`), width constant for the latency counter (`$clog2(RD_LATENCY+1)`), and index width (`$clog2(NODES)`).
- Sub-module `mpsoc_rr_arbiter`: a combinational request-vector-plus-pointer to one-hot/index winner. In the fixed-priority build it reduces to a priority encoder.
- The top level holds the FSM, latch registers, latency counter and `req_dout` array.

## Test plan
- **Single write:** `NODES`=8, `req_en[3]`=1, we=1, addr=0x100, din=0xDEADBEEF.
  - `mem_en`/`mem_we`=1 with addr 0x100 and data 0xDEADBEEF in r+1.
  - `req_ack[3]` pulse in r+2.
- **Single read:** `RD_LATENCY`=2, `req_en[5]` read of addr 0x40, memory returns 0x12345678.
  - `req_ack[5]` in r+4 with `req_dout[5]`=0x12345678.
  - Other `req_dout` entries stay 0.
- **Round-robin:** requesters 0, 2 and 7 held high continuously.
  - Grant order is 0, 2, 7, 0, 2, 7.
  - With `MPSOC_BB_ARB_RR_EN` undefined, 0 is granted every time.
- **Withdrawal after grant:** `req_en[1]` dropped in r+1 of a read.
  - The access still completes, and `req_ack[1]` still pulses.
- **Back-to-back same requester:** `req_en[4]` held high across the ack.
  - Two consecutive writes are issued.
  - `mem_en` cycles are spaced by exactly 3 cycles.
- **Reset mid-read:** assert `rst` during WAIT.
  - All outputs are 0 in the same cycle and no ack is issued.
  - After release, a pending request on requester 6 is granted first before higher indices, because the pointer was reset.
